regfile_scoreboard: RTL and testbench
=====================================

Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the RV32I core. Generalises the fixed 5-to-32 write-select decoder into a complete storage block.
- Contains:
  - a decoded one-hot write select,
  - DEPTH x WIDTH storage,
  - two asynchronous read ports,
  - a per-register pending-write scoreboard used by the issue stage for RAW hazard stalls.
- Sits between decode/issue (read ports, scoreboard set) and writeback (write port, scoreboard clear).

Parameters:
- WIDTH, 32, data width of each register.
- ADDR_W, 5, register index width; DEPTH = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero, never written and never marked busy.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- wright_en  input  1  writeback write enable.
- wright_reg  input  ADDR_W  writeback destination index.
- wright_data  input  WIDTH  writeback data.
- issue_en  input  1  an instruction with a destination register is issued this cycle.
- issue_reg  input  ADDR_W  destination index of the issued instruction.
- rs1_addr  input  ADDR_W  read port 1 index.
- rs2_addr  input  ADDR_W  read port 2 index.
- rs1_data  output  WIDTH  read port 1 data.
- rs2_data  output  WIDTH  read port 2 data.
- rs1_busy  output  1  pending write exists for rs1_addr.
- rs2_busy  output  1  pending write exists for rs2_addr.
- choose_reg  output  DEPTH  one-hot decoded write select (combinational).
- busy_vec  output  DEPTH  current scoreboard bits.

Behaviour:
- choose_reg is combinational:
  - bit wright_reg = 1 when wright_en = 1, else all zero.
  - With ZERO_REG = 1, bit 0 is forced to 0.
- Storage write:
  - On rising clk with rst = 0, every register whose choose_reg bit is 1 loads wright_data.
  - Write latency is 1 cycle; the new value is visible on read ports the cycle after the edge.
- Reads:
  - Combinational from storage: rs1_data = reg[rs1_addr], rs2_data = reg[rs2_addr].
  - With ZERO_REG = 1, index 0 always reads 0.
- Scoreboard: one busy bit per register.
  - Set at the clock edge when issue_en = 1, at bit issue_reg.
  - Cleared at the clock edge when wright_en = 1, at bit wright_reg.
  - Same cycle, same index, issue and writeback both asserted: the set wins and busy stays 1. The new producer is outstanding.
  - Same cycle, different indices: both take effect.
  - Re-issue to an already busy register: stays 1; no count is kept.
  - Writeback to a non-busy register: data is written and the busy bit stays 0.
  - With ZERO_REG = 1, issue_reg = 0 and wright_reg = 0 have no effect on the scoreboard.
- rs1_busy = busy_vec[rs1_addr]; rs2_busy = busy_vec[rs2_addr]. Both are combinational from registered state.
- Reset:
  - On a rising edge with rst = 1, all registers go to 0 and all busy bits go to 0.
  - rst overrides any simultaneous write or issue, including a reset asserted mid-sequence.
  - Outputs after reset: rs1_data = rs2_data = 0, busy outputs = 0, busy_vec = 0.
  - choose_reg still follows wright_en/wright_reg combinationally during reset; storage ignores it.
- No X propagation: all storage and busy bits are reset.

Optional Feature:
- Macro WRITE_BYPASS_EN.
- Defined:
  - When wright_en = 1, wright_reg equals a read address, and the index is non-zero (or ZERO_REG = 0), that read port returns wright_data in the same cycle.
  - The matching rsN_busy is forced to 0 that cycle unless issue_en targets the same index in the same cycle.
- Undefined:
  - Reads always return stored contents; the new value appears the next cycle.
  - rsN_busy reflects the registered scoreboard only.

Test Plan:
- Reset then read all: rst = 1 for 2 cycles, sweep rs1_addr 0..31 -> rs1_data = 0, busy_vec = 0.
- Write/read and decode:
  - wright_en = 1, wright_reg = 5, wright_data = 32'hDEADBEEF -> choose_reg = 32'h00000020 in the same cycle.
  - Next cycle, rs2_addr = 5 -> rs2_data = 32'hDEADBEEF.
  - With WRITE_BYPASS_EN, rs2_data = 32'hDEADBEEF in the write cycle.
- x0 protection: write 32'h12345678 to index 0 and issue_reg = 0 -> choose_reg = 0, rs1_data(0) = 0, busy_vec[0] = 0.
- Scoreboard lifecycle:
  - Issue reg 7 -> busy_vec = 32'h00000080, rs1_busy = 1 for rs1_addr = 7.
  - Writeback reg 7 -> busy clears the next cycle.
- Simultaneous issue/writeback: with busy[9] = 1, assert issue_reg = 9 and wright_reg = 9 together -> busy[9] stays 1 and data is updated. Same with issue 3 / writeback 9 -> busy[3] = 1, busy[9] = 0.
- Reset mid-operation: busy_vec = 32'h0000F0F0 and reg 4 = 32'hA5A5A5A5, assert rst with wright_en = 1 -> all zero next cycle and the write is discarded.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   Integer register file for the RV32I core with a per-register pending-write
//   scoreboard. Decode/issue reads operands and marks destinations busy.
//   Writeback stores results and clears the busy bit of the written register.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   wright_en     writeback write enable
//   wright_reg    writeback destination index
//   wright_data   writeback data
//   issue_en      an instruction with a destination is issued this cycle
//   issue_reg     destination index of that instruction
//   rs1_addr      read port 1 index
//   rs2_addr      read port 2 index
//   rs1_data      read port 1 data (asynchronous)
//   rs2_data      read port 2 data (asynchronous)
//   rs1_busy      pending write exists for rs1_addr
//   rs2_busy      pending write exists for rs2_addr
//   choose_reg    one-hot decoded write select (combinational)
//   busy_vec      current scoreboard bits
//
// Optional build macro
//   WRITE_BYPASS_EN  forwards wright_data to a matching read port in the
//                    write cycle and masks that port's busy flag.
//
// Interface contract: wright_en and issue_en are single-cycle qualifiers
// sampled at the rising edge. The block has no backpressure and accepts both
// every cycle. When the set and the clear of a busy bit land on the same index
// in the same cycle, the set wins. The newly issued producer is still
// outstanding.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
  parameter int WIDTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  localparam int DEPTH   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wright_en,
  input  logic [ADDR_W-1:0] wright_reg,
  input  logic [WIDTH-1:0]  wright_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_reg,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [WIDTH-1:0]  rs1_data,
  output logic [WIDTH-1:0]  rs2_data,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [DEPTH-1:0]  choose_reg,
  output logic [DEPTH-1:0]  busy_vec
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] busy_d;

  // Write select and issue decode. Both are forced off at index 0 when x0 is
  // hardwired, so x0 is never written and never marked busy.
  always_comb begin
    choose_reg = '0;
    set_mask   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wright_en && (wright_reg == ADDR_W'(i))) choose_reg[i] = 1'b1;
      if (issue_en  && (issue_reg  == ADDR_W'(i))) set_mask[i]   = 1'b1;
    end
    if (ZR) begin
      choose_reg[0] = 1'b0;
      set_mask[0]   = 1'b0;
    end
    // The clear is applied first and the set is OR-ed afterwards, so the set
    // wins on an index collision.
    busy_d = (busy_q & ~choose_reg) | set_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (choose_reg[i]) regs[i] <= wright_data;
      end
      busy_q <= busy_d;
    end
  end

  logic             rs1_zero;
  logic             rs2_zero;
  logic [WIDTH-1:0] rs1_stored;
  logic [WIDTH-1:0] rs2_stored;

  always_comb begin
    rs1_zero   = ZR && (rs1_addr == '0);
    rs2_zero   = ZR && (rs2_addr == '0);
    rs1_stored = rs1_zero ? '0 : regs[rs1_addr];
    rs2_stored = rs2_zero ? '0 : regs[rs2_addr];
  end

`ifdef WRITE_BYPASS_EN
  logic rs1_hit;
  logic rs2_hit;

  // A write in flight to a read index is forwarded. Its busy flag is masked
  // because the value is available now. The exception is a new producer
  // issued to the same index in this cycle.
  always_comb begin
    rs1_hit  = wright_en && (wright_reg == rs1_addr) && !rs1_zero;
    rs2_hit  = wright_en && (wright_reg == rs2_addr) && !rs2_zero;
    rs1_data = rs1_hit ? wright_data : rs1_stored;
    rs2_data = rs2_hit ? wright_data : rs2_stored;
    rs1_busy = busy_q[rs1_addr];
    rs2_busy = busy_q[rs2_addr];
    if (rs1_hit && !(issue_en && (issue_reg == rs1_addr))) rs1_busy = 1'b0;
    if (rs2_hit && !(issue_en && (issue_reg == rs2_addr))) rs2_busy = 1'b0;
  end
`else
  always_comb begin
    rs1_data = rs1_stored;
    rs2_data = rs2_stored;
    rs1_busy = busy_q[rs1_addr];
    rs2_busy = busy_q[rs2_addr];
  end
`endif

  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//   Self-checking bench for regfile_scoreboard (default parameters: 32 x 32,
//   x0 hardwired). It applies directed vectors from a table, then hand-written
//   multi-cycle sequences, then random traffic. All traffic is checked against
//   an array model of the register file and the busy flags.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        wright_en;
  logic [4:0]  wright_reg;
  logic [31:0] wright_data;
  logic        issue_en;
  logic [4:0]  issue_reg;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [31:0] choose_reg;
  logic [31:0] busy_vec;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk        (clk),
    .rst        (rst),
    .wright_en  (wright_en),
    .wright_reg (wright_reg),
    .wright_data(wright_data),
    .issue_en   (issue_en),
    .issue_reg  (issue_reg),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .choose_reg (choose_reg),
    .busy_vec   (busy_vec)
  );

  // ---------------- reference model ----------------
  // Register contents and pending flags kept as plain arrays.
  logic [31:0] m_mem [32];
  bit          m_busy [32];

  // Applies the architectural rules at a clock edge. A writeback retires the
  // pending flag first. An issue then makes its destination pending again.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'd0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wright_en && wright_reg != 5'd0) begin
        m_mem[wright_reg]  = wright_data;
        m_busy[wright_reg] = 1'b0;
      end
      if (issue_en && issue_reg != 5'd0) m_busy[issue_reg] = 1'b1;
    end
  endtask

  function automatic logic [31:0] m_choose();
    if (wright_en && wright_reg != 5'd0) return 32'd1 << wright_reg;
    return 32'd0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
`ifdef WRITE_BYPASS_EN
    if (wright_en && wright_reg == a && a != 5'd0) return wright_data;
`endif
    if (a == 5'd0) return 32'd0;
    return m_mem[a];
  endfunction

  function automatic logic m_pending(input logic [4:0] a);
`ifdef WRITE_BYPASS_EN
    if (wright_en && wright_reg == a && a != 5'd0 && !(issue_en && issue_reg == a))
      return 1'b0;
`endif
    return m_busy[a];
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic set_idle();
    wright_en   = 1'b0;
    wright_reg  = 5'd0;
    wright_data = 32'd0;
    issue_en    = 1'b0;
    issue_reg   = 5'd0;
  endtask

  task automatic drive(input logic we, input logic [4:0] wr, input logic [31:0] wd,
                       input logic ie, input logic [4:0] ir);
    wright_en   = we;
    wright_reg  = wr;
    wright_data = wd;
    issue_en    = ie;
    issue_reg   = ir;
  endtask

  // ---------------- directed vector table ----------------
  // One operation cycle each. choose_reg is checked before the edge. Reads,
  // busy flags and busy_vec are checked after the edge with the ports idle.
  typedef struct {
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ir;
    logic [31:0] exp_choose;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_vec;
    logic        exp_b1;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h00000020, 5'd5,  5'd0, 32'hDEADBEEF, 32'h0,        32'h0,        1'b0};
    tbl[1] = '{1'b1, 5'd0,  32'h12345678, 1'b1, 5'd0, 32'h00000000, 5'd0,  5'd5, 32'h0,        32'hDEADBEEF, 32'h0,        1'b0};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 32'h00000000, 5'd7,  5'd5, 32'h0,        32'hDEADBEEF, 32'h00000080, 1'b1};
    tbl[3] = '{1'b1, 5'd7,  32'h00000077, 1'b0, 5'd0, 32'h00000080, 5'd7,  5'd5, 32'h00000077, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9, 32'h00000000, 5'd9,  5'd7, 32'h0,        32'h00000077, 32'h00000200, 1'b1};
    tbl[5] = '{1'b1, 5'd9,  32'h00000099, 1'b1, 5'd9, 32'h00000200, 5'd9,  5'd7, 32'h00000099, 32'h00000077, 32'h00000200, 1'b1};
    tbl[6] = '{1'b1, 5'd9,  32'h0000009A, 1'b1, 5'd3, 32'h00000200, 5'd9,  5'd3, 32'h0000009A, 32'h0,        32'h00000008, 1'b0};
    tbl[7] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 32'h00000000, 5'd3,  5'd9, 32'h0,        32'h0000009A, 32'h00000008, 1'b1};
    tbl[8] = '{1'b1, 5'd3,  32'h00000033, 1'b0, 5'd0, 32'h00000008, 5'd3,  5'd9, 32'h00000033, 32'h0000009A, 32'h0,        1'b0};
    tbl[9] = '{1'b1, 5'd12, 32'h0000C0C0, 1'b0, 5'd0, 32'h00001000, 5'd12, 5'd0, 32'h0000C0C0, 32'h0,        32'h0,        1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [4:0] hot_regs [8];
    hot_regs = '{5'd4, 5'd5, 5'd6, 5'd7, 5'd12, 5'd13, 5'd14, 5'd15};

    rst = 1'b1;
    set_idle();
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #2;

    // choose_reg follows the write port even while reset is held.
    drive(1'b1, 5'd2, 32'hFFFF0000, 1'b1, 5'd2);
    #1;
    check("choose_during_rst", choose_reg, 32'h00000004);
    tick();
    tick();
    rst = 1'b0;
    set_idle();
    #1;
    check("busy_vec_after_rst", busy_vec, 32'h0);
    for (int a = 0; a < 32; a++) begin
      rs1_addr = 5'(a);
      #1;
      check($sformatf("rst_rd1[%0d]", a), rs1_data, 32'h0);
      check($sformatf("rst_busy1[%0d]", a), {31'd0, rs1_busy}, 32'h0);
    end

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].ie, tbl[i].ir);
      rs1_addr = tbl[i].ra1;
      rs2_addr = tbl[i].ra2;
      #1;
      check($sformatf("tbl%0d_choose", i), choose_reg, tbl[i].exp_choose);
      tick();
      set_idle();
      #1;
      check($sformatf("tbl%0d_rd1", i),  rs1_data, tbl[i].exp_rd1);
      check($sformatf("tbl%0d_rd2", i),  rs2_data, tbl[i].exp_rd2);
      check($sformatf("tbl%0d_vec", i),  busy_vec, tbl[i].exp_vec);
      check($sformatf("tbl%0d_busy1", i), {31'd0, rs1_busy}, {31'd0, tbl[i].exp_b1});
    end

    // Same-cycle read of a register being written.
    drive(1'b1, 5'd5, 32'hCAFEF00D, 1'b0, 5'd0);
    rs2_addr = 5'd5;
    #1;
`ifdef WRITE_BYPASS_EN
    check("same_cycle_rd2", rs2_data, 32'hCAFEF00D);
`else
    check("same_cycle_rd2", rs2_data, 32'hDEADBEEF);
`endif
    tick();
    set_idle();
    #1;
    check("next_cycle_rd2", rs2_data, 32'hCAFEF00D);

    // Same-cycle busy flag of a pending register being written back.
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd10);
    tick();
    drive(1'b1, 5'd10, 32'h1010, 1'b0, 5'd0);
    rs1_addr = 5'd10;
    #1;
`ifdef WRITE_BYPASS_EN
    check("wb_cycle_busy1", {31'd0, rs1_busy}, 32'h0);
`else
    check("wb_cycle_busy1", {31'd0, rs1_busy}, 32'h1);
`endif
    tick();
    set_idle();
    #1;
    check("after_wb_busy1", {31'd0, rs1_busy}, 32'h0);

    // Reset in the middle of activity discards the simultaneous write and issue.
    drive(1'b1, 5'd4, 32'hA5A5A5A5, 1'b0, 5'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, hot_regs[i]);
      tick();
    end
    set_idle();
    rs1_addr = 5'd4;
    rs2_addr = 5'd5;
    #1;
    check("pre_rst_vec", busy_vec, 32'h0000F0F0);
    check("pre_rst_rd1", rs1_data, 32'hA5A5A5A5);
    rst = 1'b1;
    drive(1'b1, 5'd4, 32'hFFFFFFFF, 1'b1, 5'd2);
    tick();
    set_idle();
    #1;
    check("mid_rst_vec", busy_vec, 32'h0);
    check("mid_rst_rd1", rs1_data, 32'h0);
    check("mid_rst_rd2", rs2_data, 32'h0);
    rst = 1'b0;
    tick();

    // Random traffic against the model. Indices are biased toward a small
    // range so collisions between ports happen often.
    for (int n = 0; n < 400; n++) begin
      rst         = ($urandom_range(0, 39) == 0);
      wright_en   = 1'($urandom_range(0, 1));
      wright_reg  = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      wright_data = $urandom;
      issue_en    = 1'($urandom_range(0, 1));
      issue_reg   = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs1_addr    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      rs2_addr    = ($urandom_range(0, 1) != 0) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      #1;
      exp_q.push_back(m_choose());
      exp_q.push_back(m_read(rs1_addr));
      exp_q.push_back(m_read(rs2_addr));
      exp_q.push_back(m_vec());
      exp_q.push_back({30'd0, m_pending(rs1_addr), m_pending(rs2_addr)});
      check("rnd_choose", choose_reg, exp_q.pop_front());
      check("rnd_rd1", rs1_data, exp_q.pop_front());
      check("rnd_rd2", rs2_data, exp_q.pop_front());
      check("rnd_vec", busy_vec, exp_q.pop_front());
      check("rnd_busy", {30'd0, rs1_busy, rs2_busy}, exp_q.pop_front());
      tick();
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
